// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//
// Instruction-fetch and stage sequencer for the multi-cycle RV32 core. Holds
// the program counter, runs a req/ack fetch against instruction memory,
// latches the instruction word that decode reads as its IR, and walks the
// stage select FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK. Branch/jump
// redirects from execute are applied when the instruction retires.
//
// Ports
//   clk            core clock, all state changes on the rising edge
//   reset          asynchronous, active-high reset
//   imem_req_o     fetch request (high exactly while in FETCH)
//   imem_addr_o    fetch address, always equal to pc_o
//   imem_data_i    instruction word, valid with imem_ack_i
//   imem_ack_i     memory acknowledge (ignored outside FETCH)
//   ir_o           latched instruction word for decode
//   pc_o           PC of the instruction in ir_o
//   stage_o        current stage code
//   stall_i        hold request, honoured in EXECUTE and MEMORY only
//   redirect_i     taken branch/jump, sampled on the EXECUTE exit cycle
//   redirect_pc_i  redirect target
//   retire_o       one-cycle pulse while in WRITEBACK
//   fault_o        sticky fault (fetch timeout or misaligned redirect)
//
// Stages
//   stage      | code | meaning
//   FETCH      | 0    | request instruction at pc, wait for ack or timeout
//   DECODE     | 1    | single cycle, decode reads ir_o
//   EXECUTE    | 2    | hold on stall, compute next pc on exit
//   MEMORY     | 3    | hold on stall
//   WRITEBACK  | 4    | single cycle, retire pulse, pc <= next pc
//   HALT       | 7    | fault terminal state, left only through reset
// Codes 5 and 6 are never produced; if ever seen they behave as HALT.
// -----------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_ack_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic [2:0]  stage_o,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        retire_o,
    output logic        fault_o
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd7
    } stage_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // A zero-width counter is not legal, so the timeout-disabled case keeps
    // one idle bit.
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    stage_e              stage_q,   stage_d;
    logic [31:0]         pc_q,      pc_d;
    logic [31:0]         next_pc_q, next_pc_d;
    logic [31:0]         ir_q,      ir_d;
    logic                fault_q,   fault_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;

    logic                timeout;
    logic                redirect_misaligned;

    assign timeout             = (MAX_WAIT != 0) && (wait_q == WAIT_LIMIT);
    assign redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            ir_q      <= NOP_INSN;
            fault_q   <= 1'b0;
            wait_q    <= '0;
        end else begin
            stage_q   <= stage_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            ir_q      <= ir_d;
            fault_q   <= fault_d;
            wait_q    <= wait_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        stage_d   = stage_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        ir_d      = ir_q;
        fault_d   = fault_q;
        wait_d    = wait_q;

        case (stage_q)
            ST_FETCH: begin
                // Ack has priority over a timeout landing on the same edge.
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    wait_d  = '0;
                    stage_d = ST_DECODE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    stage_d = ST_HALT;
                end else if (MAX_WAIT != 0) begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end

            ST_DECODE: begin
                stage_d = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                // Redirect is only looked at on the cycle the stage is left.
                if (!stall_i) begin
                    if (redirect_i) begin
                        if (redirect_misaligned) begin
                            fault_d = 1'b1;
                            stage_d = ST_HALT;
                        end else begin
                            next_pc_d = redirect_pc_i;
                            stage_d   = ST_MEMORY;
                        end
                    end else begin
                        next_pc_d = pc_q + 32'd4;
                        stage_d   = ST_MEMORY;
                    end
                end
            end

            ST_MEMORY: begin
                if (!stall_i) begin
                    stage_d = ST_WRITEBACK;
                end
            end

            ST_WRITEBACK: begin
                pc_d    = next_pc_q;
                stage_d = ST_FETCH;
            end

            default: begin
                stage_d = ST_HALT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: request and retire come straight off the stage register so they
    // cannot glitch on input activity.
    // -------------------------------------------------------------------------
    assign imem_req_o  = (stage_q == ST_FETCH);
    assign retire_o    = (stage_q == ST_WRITEBACK);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign ir_o        = ir_q;
    assign stage_o     = stage_q;
    assign fault_o     = fault_q;

endmodule
